// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types, widths and helpers for the DMA channel scheduler
package dma_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    localparam int DMA_ADDR_W = 32;
    localparam int DMA_LEN_W = 32;
    localparam int WDOG_W = 32;
    function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/dma_channel_scheduler_if.sv
// dma_channel_scheduler_if: requester descriptors plus the DMA engine control bundle
interface dma_channel_scheduler_if #(parameter int NUM_CH = 4);
    import dma_sched_pkg::*;
    localparam int CH_W = $clog2(NUM_CH);
    logic [NUM_CH-1:0] ch_req_valid;
    logic [NUM_CH-1:0] ch_req_ready;
    logic [NUM_CH*DMA_ADDR_W-1:0] ch_src;
    logic [NUM_CH*DMA_ADDR_W-1:0] ch_dst;
    logic [NUM_CH*DMA_LEN_W-1:0] ch_len;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_err;
    logic dma_en;
    logic [DMA_ADDR_W-1:0] dma_src;
    logic [DMA_ADDR_W-1:0] dma_dst;
    logic [DMA_LEN_W-1:0] dma_len;
    logic dma_done;
    logic busy;
    logic [CH_W-1:0] cur_ch;
    modport master (
        output ch_req_valid, ch_src, ch_dst, ch_len, dma_done,
        input ch_req_ready, ch_done, ch_err, dma_en, dma_src, dma_dst, dma_len, busy, cur_ch
    );
    modport slave (
        input ch_req_valid, ch_src, ch_dst, ch_len, dma_done,
        output ch_req_ready, ch_done, ch_err, dma_en, dma_src, dma_dst, dma_len, busy, cur_ch
    );
endinterface

// File: rtl/dma_channel_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick starting after the last grant; pointer moves only on advance
module rr_arbiter #(
    parameter int N = 4
) (
    input logic clk,
    input logic rst,
    input logic [N-1:0] req,
    input logic advance,
    output logic [N-1:0] grant,
    output logic [$clog2(N)-1:0] idx,
    output logic any
);
    localparam int W = $clog2(N);
    logic [W-1:0] ptr;
    logic [W-1:0] c;
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        c = '0;
        for (int k = 1; k <= N; k++) begin
            c = W'((32'(ptr) + 32'(k)) % 32'(N));
            if (!any && req[c]) begin
                grant[c] = 1'b1;
                idx = c;
                any = 1'b1;
            end
        end
    end
    // Reset pointer at the last channel so channel 0 is searched first
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= W'(N - 1);
        else if (advance && any)
            ptr <= idx;
    end
endmodule

// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: round-robin descriptor intake and single-engine sequencing with watchdog
module dma_channel_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TIMEOUT = 4096
) (
    input logic clk,
    input logic rst,
    dma_channel_scheduler_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT - 1);
    state_e state_q, state_d;
    logic [NUM_CH-1:0] arb_req, grant;
    logic [CH_W-1:0] g;
    logic any;
    logic [DMA_ADDR_W-1:0] src_g, dst_g;
    logic [DMA_LEN_W-1:0] len_g;
    logic [WDOG_W-1:0] wdog;
    logic timeout;
    // A high interrupt blocks grants so a stale completion can't close the next job
    assign arb_req = (state_q == IDLE && !bus.dma_done) ? bus.ch_req_valid : '0;
    assign bus.ch_req_ready = grant;
    assign src_g = bus.ch_src[DMA_ADDR_W*int'(g) +: DMA_ADDR_W];
    assign dst_g = bus.ch_dst[DMA_ADDR_W*int'(g) +: DMA_ADDR_W];
    assign len_g = bus.ch_len[DMA_LEN_W*int'(g) +: DMA_LEN_W];
    assign timeout = (TIMEOUT != 0) && (wdog == WD_LAST);
    assign bus.busy = state_q != IDLE;
    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(arb_req),
        .advance(any),
        .grant(grant),
        .idx(g),
        .any(any)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any && len_g != '0) state_d = RUN;
            RUN: if (bus.dma_done || timeout) state_d = DRAIN;
            DRAIN: if (!bus.dma_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bus.dma_en <= 1'b0;
            bus.dma_src <= '0;
            bus.dma_dst <= '0;
            bus.dma_len <= '0;
            bus.ch_done <= '0;
            bus.ch_err <= '0;
            bus.cur_ch <= '0;
            wdog <= '0;
        end else begin
            state_q <= state_d;
            bus.ch_done <= '0;
            bus.ch_err <= '0;
            if (state_q == IDLE && any) begin
                bus.dma_src <= src_g;
                bus.dma_dst <= dst_g;
                bus.dma_len <= len_g;
                bus.cur_ch <= g;
                wdog <= '0;
                if (len_g == '0)
                    bus.ch_err <= grant;
                else
                    bus.dma_en <= 1'b1;
            end
            // Completion outranks the watchdog when both land together
            if (state_q == RUN) begin
                wdog <= sat_inc(wdog);
                if (bus.dma_done) begin
                    bus.dma_en <= 1'b0;
                    bus.ch_done[bus.cur_ch] <= 1'b1;
                end else if (timeout) begin
                    bus.dma_en <= 1'b0;
                    bus.ch_err[bus.cur_ch] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb_dma_channel_scheduler: directed sequence with grant/completion scoreboard queues
module tb_dma_channel_scheduler;
    localparam int N = 4;
    localparam int TO = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dma_channel_scheduler_if #(.NUM_CH(N)) bus ();
    dma_channel_scheduler #(.NUM_CH(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] src [N];
    logic [31:0] dst [N];
    logic [31:0] len [N];
    assign bus.ch_src = {src[3], src[2], src[1], src[0]};
    assign bus.ch_dst = {dst[3], dst[2], dst[1], dst[0]};
    assign bus.ch_len = {len[3], len[2], len[1], len[0]};
    typedef struct {int ch; bit err;} out_t;
    out_t out_q[$];
    int grant_q[$];
    int errors = 0;
    int checks = 0;
    bit exp_en = 1'b0;
    int e_ch;
    logic [31:0] e_src, e_dst, e_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_ready();
        if (bus.ch_req_ready != '0) begin
            chk("ready_while_done", 64'(bus.dma_done), 0);
            if (grant_q.size() == 0) begin
                chk("grant_unexpected", 64'(bus.ch_req_ready), 0);
            end else begin
                e_ch = grant_q.pop_front();
                chk("grant", 64'(bus.ch_req_ready), 64'(1) << e_ch);
                e_src = src[e_ch];
                e_dst = dst[e_ch];
                e_len = len[e_ch];
                exp_en = (len[e_ch] != 0);
            end
        end
    endtask

    task automatic mon_regs();
        out_t o;
        if (exp_en) begin
            exp_en = 1'b0;
            chk("en_after_accept", 64'(bus.dma_en), 1);
            chk("dma_src", 64'(bus.dma_src), 64'(e_src));
            chk("dma_dst", 64'(bus.dma_dst), 64'(e_dst));
            chk("dma_len", 64'(bus.dma_len), 64'(e_len));
            chk("cur_ch", 64'(bus.cur_ch), 64'(e_ch));
        end
        if (|bus.ch_done || |bus.ch_err) begin
            if (out_q.size() == 0) begin
                chk("done_unexpected", 64'(bus.ch_done), 0);
                chk("err_unexpected", 64'(bus.ch_err), 0);
            end else begin
                o = out_q.pop_front();
                chk("ch_done", 64'(bus.ch_done), o.err ? 64'(0) : 64'(1) << o.ch);
                chk("ch_err", 64'(bus.ch_err), o.err ? 64'(1) << o.ch : 64'(0));
            end
        end
    endtask

    task automatic cyc();
        #1;
        mon_ready();
        @(posedge clk);
        @(negedge clk);
        mon_regs();
    endtask

    task automatic wait_en(input logic v);
        int n = 0;
        while (bus.dma_en !== v && n < 300) begin
            cyc();
            n++;
        end
        chk("wait_en", 64'(bus.dma_en), 64'(v));
    endtask

    initial begin
        int n;
        bus.ch_req_valid = '0;
        bus.dma_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            src[i] = '0;
            dst[i] = '0;
            len[i] = '0;
        end
        @(negedge clk);
        repeat (3) cyc();
        chk("rst_dma_en", 64'(bus.dma_en), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_cur_ch", 64'(bus.cur_ch), 0);
        chk("rst_dma_src", 64'(bus.dma_src), 0);
        chk("rst_dma_len", 64'(bus.dma_len), 0);
        chk("rst_done", 64'(bus.ch_done), 0);
        chk("rst_err", 64'(bus.ch_err), 0);
        rst = 1'b0;
        cyc();
        // single transfer on channel 0
        src[0] = 32'h1000;
        dst[0] = 32'h2000;
        len[0] = 32'd16;
        bus.ch_req_valid = 4'b0001;
        grant_q.push_back(0);
        out_q.push_back('{ch: 0, err: 1'b0});
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        chk("t1_busy_run", 64'(bus.busy), 1);
        repeat (19) cyc();
        chk("t1_en_hold", 64'(bus.dma_en), 1);
        bus.dma_done = 1'b1;
        cyc();
        chk("t1_en_drop", 64'(bus.dma_en), 0);
        chk("t1_busy_drain", 64'(bus.busy), 1);
        bus.dma_done = 1'b0;
        cyc();
        chk("t1_busy_idle", 64'(bus.busy), 0);
        // all channels continuously valid from a fresh pointer
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src[i] = 32'h4000 + 32'(i) * 32'h100;
            dst[i] = 32'h8000 + 32'(i) * 32'h100;
            len[i] = 32'(i + 1);
        end
        bus.ch_req_valid = '1;
        foreach (grant_q[i]) grant_q.delete(i);
        grant_q = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) out_q.push_back('{ch: grant_q[i], err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            wait_en(1'b1);
            if (i == 4) bus.ch_req_valid = '0;
            repeat (3) cyc();
            bus.dma_done = 1'b1;
            repeat (3) cyc();
            chk("t2_en_drain", 64'(bus.dma_en), 0);
            bus.dma_done = 1'b0;
            cyc();
        end
        // zero-length descriptor on channel 2, then channel 3 served
        len[2] = 32'd0;
        len[3] = 32'd5;
        bus.ch_req_valid = 4'b1100;
        grant_q.push_back(2);
        grant_q.push_back(3);
        out_q.push_back('{ch: 2, err: 1'b1});
        out_q.push_back('{ch: 3, err: 1'b0});
        cyc();
        bus.ch_req_valid[2] = 1'b0;
        chk("t3_en_zero", 64'(bus.dma_en), 0);
        chk("t3_busy_zero", 64'(bus.busy), 0);
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        cyc();
        bus.dma_done = 1'b1;
        cyc();
        bus.dma_done = 1'b0;
        cyc();
        // watchdog expiry on channel 1
        len[1] = 32'd8;
        bus.ch_req_valid = 4'b0010;
        grant_q.push_back(1);
        out_q.push_back('{ch: 1, err: 1'b1});
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        n = 0;
        while (bus.dma_en === 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk("t4_run_cycles", 64'(n), 64'(TO));
        chk("t4_busy_drain", 64'(bus.busy), 1);
        cyc();
        chk("t4_busy_idle", 64'(bus.busy), 0);
        // completion coincides with watchdog expiry on channel 2
        len[2] = 32'd9;
        bus.ch_req_valid = 4'b0100;
        grant_q.push_back(2);
        out_q.push_back('{ch: 2, err: 1'b0});
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        repeat (TO - 1) cyc();
        bus.dma_done = 1'b1;
        cyc();
        chk("t5_en_drop", 64'(bus.dma_en), 0);
        bus.dma_done = 1'b0;
        cyc();
        chk("t5_busy_idle", 64'(bus.busy), 0);
        // interrupt stuck high while idle blocks all grants
        bus.dma_done = 1'b1;
        bus.ch_req_valid = 4'b1000;
        repeat (4) begin
            #1;
            chk("t5_stuck_ready", 64'(bus.ch_req_ready), 0);
            cyc();
        end
        chk("t5_stuck_busy", 64'(bus.busy), 0);
        bus.dma_done = 1'b0;
        grant_q.push_back(3);
        out_q.push_back('{ch: 3, err: 1'b0});
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        cyc();
        bus.dma_done = 1'b1;
        cyc();
        bus.dma_done = 1'b0;
        cyc();
        // reset in the middle of a transfer drops it silently
        bus.ch_req_valid = 4'b0010;
        grant_q.push_back(1);
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        chk("t6_dma_en", 64'(bus.dma_en), 0);
        chk("t6_busy", 64'(bus.busy), 0);
        chk("t6_cur_ch", 64'(bus.cur_ch), 0);
        chk("t6_dma_src", 64'(bus.dma_src), 0);
        chk("t6_dma_dst", 64'(bus.dma_dst), 0);
        chk("t6_dma_len", 64'(bus.dma_len), 0);
        chk("t6_done", 64'(bus.ch_done), 0);
        chk("t6_err", 64'(bus.ch_err), 0);
        rst = 1'b0;
        bus.ch_req_valid = 4'b0111;
        grant_q.push_back(0);
        out_q.push_back('{ch: 0, err: 1'b0});
        wait_en(1'b1);
        bus.ch_req_valid = '0;
        cyc();
        bus.dma_done = 1'b1;
        cyc();
        bus.dma_done = 1'b0;
        repeat (2) cyc();
        chk("grant_q_empty", 64'(grant_q.size()), 0);
        chk("out_q_empty", 64'(out_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
